// File: rtl/wb_bus_master_if.sv
// Wishbone classic bus between the bus master stage and the interconnect.
// The device select travels with the cycle so the interconnect can decode the slave.
interface wb_bus_master_if;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic [15:0] wb_dev_sel_o;
   logic        wb_ack_i;

   modport master (
      output wb_adr_o,
      output wb_dat_o,
      output wb_we_o,
      output wb_sel_o,
      output wb_stb_o,
      output wb_cyc_o,
      output wb_dev_sel_o,
      input  wb_dat_i,
      input  wb_ack_i
   );

   modport slave (
      input  wb_adr_o,
      input  wb_dat_o,
      input  wb_we_o,
      input  wb_sel_o,
      input  wb_stb_o,
      input  wb_cyc_o,
      input  wb_dev_sel_o,
      output wb_dat_i,
      output wb_ack_i
   );
endinterface

// File: rtl/wb_bus_master.sv
// Wishbone master stage behind the MMU: one classic cycle per CPU access, holding
// the pipeline until ack, timeout or unmapped termination, and buffering read data.
//
// state          | meaning
// S_IDLE         | no cycle in flight; accepts a request when ce=1 and no flush
// S_BUSY         | stb/cyc asserted, waiting for ack or timeout
// S_WAIT_FOR_STALL | access finished, read data held in rd_buf until fetch stage released
module wb_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255,   // 1..255
   parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce_i,
   input  logic        cpu_we_i,
   input  logic [3:0]  cpu_sel_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [15:0] cpu_dev_sel_i,
   input  logic [31:0] cpu_data_i,
   output logic [31:0] cpu_data_o,
   output logic        stallreq_o,
   input  logic [5:0]  stall_i,
   input  logic        flush_i,
   output logic        bus_err_o,
   wb_bus_master_if.master wb
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_WAIT_FOR_STALL
   } state_e;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic        stb_q, stb_d;
   logic        cyc_q, cyc_d;
   logic [15:0] dev_sel_q, dev_sel_d;
   logic [31:0] rd_buf_q, rd_buf_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;

   // Only the fetch-stage hold bit matters to this stage.
   logic unused_stall;
   assign unused_stall = ^stall_i[5:1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         adr_q     <= '0;
         dat_q     <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         stb_q     <= 1'b0;
         cyc_q     <= 1'b0;
         dev_sel_q <= '0;
         rd_buf_q  <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         stb_q     <= stb_d;
         cyc_q     <= cyc_d;
         dev_sel_q <= dev_sel_d;
         rd_buf_q  <= rd_buf_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      we_d       = we_q;
      sel_d      = sel_q;
      stb_d      = stb_q;
      cyc_d      = cyc_q;
      dev_sel_d  = dev_sel_q;
      rd_buf_d   = rd_buf_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      stallreq_o = 1'b0;
      cpu_data_o = '0;

      unique case (state_q)
         S_IDLE: begin
            stallreq_o = cpu_ce_i & ~flush_i;
            if (cpu_ce_i && !flush_i) begin
               if (cpu_dev_sel_i != 16'h0000) begin
                  adr_d     = cpu_addr_i;
                  dat_d     = cpu_data_i;
                  we_d      = cpu_we_i;
                  sel_d     = cpu_sel_i;
                  dev_sel_d = cpu_dev_sel_i;
                  stb_d     = 1'b1;
                  cyc_d     = 1'b1;
                  cnt_d     = '0;
                  state_d   = S_BUSY;
               end else begin
                  rd_buf_d = ERR_DATA;
                  err_d    = 1'b1;
                  state_d  = S_WAIT_FOR_STALL;
               end
            end
         end

         S_BUSY: begin
            if (flush_i) begin
               stb_d   = 1'b0;
               cyc_d   = 1'b0;
               state_d = S_IDLE;
            end else if (wb.wb_ack_i) begin
               stb_d = 1'b0;
               cyc_d = 1'b0;
               we_d  = 1'b0;
               if (!we_q) begin
                  rd_buf_d   = wb.wb_dat_i;
                  cpu_data_o = wb.wb_dat_i;
               end
               state_d = stall_i[0] ? S_WAIT_FOR_STALL : S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               // Timeout terminates like an ack carrying the error pattern.
               stb_d = 1'b0;
               cyc_d = 1'b0;
               we_d  = 1'b0;
               err_d = 1'b1;
               if (!we_q) begin
                  rd_buf_d   = ERR_DATA;
                  cpu_data_o = ERR_DATA;
               end
               state_d = stall_i[0] ? S_WAIT_FOR_STALL : S_IDLE;
            end else begin
               cnt_d      = cnt_q + 8'd1;
               stallreq_o = 1'b1;
            end
         end

         S_WAIT_FOR_STALL: begin
            cpu_data_o = rd_buf_q;
            if (flush_i || !stall_i[0]) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign wb.wb_adr_o     = adr_q;
   assign wb.wb_dat_o     = dat_q;
   assign wb.wb_we_o      = we_q;
   assign wb.wb_sel_o     = sel_q;
   assign wb.wb_stb_o     = stb_q;
   assign wb.wb_cyc_o     = cyc_q;
   assign wb.wb_dev_sel_o = dev_sel_q;
   assign bus_err_o       = err_q;

endmodule

// File: tb/tb_wb_bus_master.sv
// Directed bench for wb_bus_master: read, write, unmapped, timeout, ack under
// external stall, flush and reset in mid-cycle.
module tb_wb_bus_master;
   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_ce_i;
   logic        cpu_we_i;
   logic [3:0]  cpu_sel_i;
   logic [31:0] cpu_addr_i;
   logic [15:0] cpu_dev_sel_i;
   logic [31:0] cpu_data_i;
   logic [31:0] cpu_data_o;
   logic        stallreq_o;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic        bus_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   wb_bus_master_if bus ();

   wb_bus_master #(
      .TIMEOUT_CYCLES(4),
      .ERR_DATA      (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_ce_i     (cpu_ce_i),
      .cpu_we_i     (cpu_we_i),
      .cpu_sel_i    (cpu_sel_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_dev_sel_i(cpu_dev_sel_i),
      .cpu_data_i   (cpu_data_i),
      .cpu_data_o   (cpu_data_o),
      .stallreq_o   (stallreq_o),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .bus_err_o    (bus_err_o),
      .wb           (bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      n_checks++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus.wb_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got cyc=%b stb=%b we=%b want 0 0 0", bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o); end
      n_checks++; if (bus.wb_adr_o !== 32'h0 || bus.wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_adr_dat: got %h %h want 0 0", bus.wb_adr_o, bus.wb_dat_o); end
      n_checks++; if (bus.wb_sel_o !== 4'h0 || bus.wb_dev_sel_o !== 16'h0) begin n_fail++; $display("FAIL reset_sel: got %h %h want 0 0", bus.wb_sel_o, bus.wb_dev_sel_o); end
      n_checks++; if (bus_err_o !== 1'b0 || stallreq_o !== 1'b0 || cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_cpu: got err=%b stall=%b data=%h want 0 0 0", bus_err_o, stallreq_o, cpu_data_o); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_read();
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      cpu_addr_i = 32'h0000_0010; cpu_dev_sel_i = 16'h0001; cpu_data_i = 32'h0;
      @(negedge clk);
      n_checks++; if (stallreq_o !== 1'b1 || bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL read_idle: got stall=%b cyc=%b want 1 0", stallreq_o, bus.wb_cyc_o); end
      tick();
      @(negedge clk);
      n_checks++; if (bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b1 || stallreq_o !== 1'b1) begin n_fail++; $display("FAIL read_busy1: got cyc=%b stb=%b stall=%b want 1 1 1", bus.wb_cyc_o, bus.wb_stb_o, stallreq_o); end
      n_checks++; if (bus.wb_adr_o !== 32'h0000_0010 || bus.wb_we_o !== 1'b0 || bus.wb_dev_sel_o !== 16'h0001) begin n_fail++; $display("FAIL read_addr: got adr=%h we=%b dev=%h want 00000010 0 0001", bus.wb_adr_o, bus.wb_we_o, bus.wb_dev_sel_o); end
      tick();
      @(negedge clk);
      n_checks++; if (bus.wb_cyc_o !== 1'b1 || stallreq_o !== 1'b1) begin n_fail++; $display("FAIL read_busy2: got cyc=%b stall=%b want 1 1", bus.wb_cyc_o, stallreq_o); end
      tick();
      bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEAD_BEEF;
      @(negedge clk);
      n_checks++; if (bus.wb_cyc_o !== 1'b1 || stallreq_o !== 1'b0 || cpu_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_ack: got cyc=%b stall=%b data=%h want 1 0 deadbeef", bus.wb_cyc_o, stallreq_o, cpu_data_o); end
      tick();
      bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0; cpu_ce_i = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus_err_o !== 1'b0 || cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL read_done: got cyc=%b stb=%b err=%b data=%h want 0 0 0 0", bus.wb_cyc_o, bus.wb_stb_o, bus_err_o, cpu_data_o); end
      tick();
   endtask

   task automatic test_write();
      cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_sel_i = 4'b0001;
      cpu_addr_i = 32'h1fd0_03f8; cpu_dev_sel_i = 16'h0002; cpu_data_i = 32'h41;
      tick();
      bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h5555_AAAA;
      @(negedge clk);
      n_checks++; if (bus.wb_we_o !== 1'b1 || bus.wb_dat_o !== 32'h41 || bus.wb_sel_o !== 4'b0001) begin n_fail++; $display("FAIL write_bus: got we=%b dat=%h sel=%b want 1 00000041 0001", bus.wb_we_o, bus.wb_dat_o, bus.wb_sel_o); end
      n_checks++; if (bus.wb_adr_o !== 32'h1fd0_03f8 || bus.wb_dev_sel_o !== 16'h0002) begin n_fail++; $display("FAIL write_addr: got %h %h want 1fd003f8 0002", bus.wb_adr_o, bus.wb_dev_sel_o); end
      n_checks++; if (stallreq_o !== 1'b0 || cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL write_ack: got stall=%b data=%h want 0 0", stallreq_o, cpu_data_o); end
      tick();
      bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0; cpu_ce_i = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_we_o !== 1'b0 || bus_err_o !== 1'b0) begin n_fail++; $display("FAIL write_done: got cyc=%b we=%b err=%b want 0 0 0", bus.wb_cyc_o, bus.wb_we_o, bus_err_o); end
      tick();
   endtask

   task automatic test_unmapped();
      // rd_buf holds DEADBEEF from the earlier read, so a zero here proves it was reloaded.
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_dev_sel_i = 16'h0000;
      cpu_addr_i = 32'hF000_0000; stall_i = 6'b000001;
      @(negedge clk);
      n_checks++; if (stallreq_o !== 1'b1 || bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL unmapped_idle: got stall=%b cyc=%b want 1 0", stallreq_o, bus.wb_cyc_o); end
      tick();
      @(negedge clk);
      n_checks++; if (bus_err_o !== 1'b1 || bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL unmapped_err: got err=%b cyc=%b want 1 0", bus_err_o, bus.wb_cyc_o); end
      n_checks++; if (stallreq_o !== 1'b0 || cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL unmapped_wait: got stall=%b data=%h want 0 0", stallreq_o, cpu_data_o); end
      tick();
      @(negedge clk);
      n_checks++; if (bus_err_o !== 1'b0 || bus.wb_cyc_o !== 1'b0 || cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL unmapped_pulse: got err=%b cyc=%b data=%h want 0 0 0", bus_err_o, bus.wb_cyc_o, cpu_data_o); end
      stall_i = 6'b0; cpu_ce_i = 1'b0;
      tick();
      @(negedge clk);
      n_checks++; if (bus_err_o !== 1'b0 || bus.wb_cyc_o !== 1'b0 || stallreq_o !== 1'b0) begin n_fail++; $display("FAIL unmapped_done: got err=%b cyc=%b stall=%b want 0 0 0", bus_err_o, bus.wb_cyc_o, stallreq_o); end
      tick();
   endtask

   task automatic test_timeout();
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      cpu_addr_i = 32'h0000_0020; cpu_dev_sel_i = 16'h0001;
      bus.wb_dat_i = 32'hFFFF_FFFF;
      for (int i = 1; i <= 4; i++) begin
         tick();
         @(negedge clk);
         n_checks++; if (bus.wb_cyc_o !== 1'b1 || stallreq_o !== (i < 4) || bus_err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_busy%0d: got cyc=%b stall=%b err=%b want 1 %b 0", i, bus.wb_cyc_o, stallreq_o, bus_err_o, (i < 4)); end
      end
      n_checks++; if (cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL timeout_data: got %h want 00000000", cpu_data_o); end
      tick();
      cpu_ce_i = 1'b0; bus.wb_dat_i = 32'h0;
      @(negedge clk);
      n_checks++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus_err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got cyc=%b stb=%b err=%b want 0 0 1", bus.wb_cyc_o, bus.wb_stb_o, bus_err_o); end
      tick();
      @(negedge clk);
      n_checks++; if (bus_err_o !== 1'b0 || bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got err=%b cyc=%b want 0 0", bus_err_o, bus.wb_cyc_o); end
      tick();
   endtask

   task automatic test_ack_during_stall();
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      cpu_addr_i = 32'h0000_0030; cpu_dev_sel_i = 16'h0001;
      tick();
      bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h1234_5678; stall_i = 6'b000001;
      @(negedge clk);
      n_checks++; if (stallreq_o !== 1'b0 || cpu_data_o !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_ack: got stall=%b data=%h want 0 12345678", stallreq_o, cpu_data_o); end
      tick();
      cpu_ce_i = 1'b0; bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0;
      for (int i = 1; i <= 3; i++) begin
         // A stray ack while waiting must not disturb the buffered data.
         if (i == 2) begin bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hAAAA_5555; end
         @(negedge clk);
         n_checks++; if (cpu_data_o !== 32'h1234_5678 || stallreq_o !== 1'b0 || bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got data=%h stall=%b cyc=%b want 12345678 0 0", i, cpu_data_o, stallreq_o, bus.wb_cyc_o); end
         tick();
         bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0;
      end
      stall_i = 6'b0;
      @(negedge clk);
      n_checks++; if (cpu_data_o !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_release: got %h want 12345678", cpu_data_o); end
      tick();
      @(negedge clk);
      n_checks++; if (cpu_data_o !== 32'h0 || stallreq_o !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got data=%h stall=%b want 0 0", cpu_data_o, stallreq_o); end
      tick();
   endtask

   task automatic test_flush();
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      cpu_addr_i = 32'h0000_0040; cpu_dev_sel_i = 16'h0004;
      tick();
      tick();
      // Ack with a held fetch stage would lead to WAIT_FOR_STALL; flush must win.
      flush_i = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0000_FACE; stall_i = 6'b000001;
      @(negedge clk);
      n_checks++; if (stallreq_o !== 1'b0 || bus.wb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL flush_busy: got stall=%b cyc=%b want 0 1", stallreq_o, bus.wb_cyc_o); end
      tick();
      flush_i = 1'b0; bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0; cpu_ce_i = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus_err_o !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got cyc=%b stb=%b err=%b want 0 0 0", bus.wb_cyc_o, bus.wb_stb_o, bus_err_o); end
      n_checks++; if (cpu_data_o !== 32'h0 || stallreq_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got data=%h stall=%b want 0 0", cpu_data_o, stallreq_o); end
      stall_i = 6'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_sel_i = 4'b0011;
      cpu_addr_i = 32'h0000_0050; cpu_dev_sel_i = 16'h0008; cpu_data_i = 32'hCAFE_0001;
      tick();
      tick();
      rst = 1'b1; cpu_ce_i = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.wb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got cyc=%b want 1", bus.wb_cyc_o); end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus.wb_we_o !== 1'b0 || bus_err_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got cyc=%b stb=%b we=%b err=%b want 0 0 0 0", bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus_err_o); end
      n_checks++; if (bus.wb_adr_o !== 32'h0 || bus.wb_dat_o !== 32'h0 || bus.wb_sel_o !== 4'h0 || bus.wb_dev_sel_o !== 16'h0) begin n_fail++; $display("FAIL rstmid_bus: got adr=%h dat=%h sel=%h dev=%h want 0 0 0 0", bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_dev_sel_o); end
      tick();
   endtask

   initial begin
      rst = 1'b1; cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_sel_i = 4'h0;
      cpu_addr_i = 32'h0; cpu_dev_sel_i = 16'h0; cpu_data_i = 32'h0;
      stall_i = 6'b0; flush_i = 1'b0;
      bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0;

      test_reset();
      test_read();
      test_write();
      test_unmapped();
      test_timeout();
      test_ack_during_stall();
      test_flush();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
